// File: rtl/comb_lock_pkg.sv
// Shared types and constants for the combination-lock controller.
package comb_lock_pkg;

   typedef enum logic [2:0] {
      IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT
   } state_e;

   localparam int         CODE_LEN   = 4;
   localparam logic [3:0] KEY_PROG   = 4'hE;
   localparam logic [3:0] KEY_CANCEL = 4'hF;
   localparam int         LED_OPEN   = 4;
   localparam int         LED_LOCK   = 5;

   // n = 0..4 lit digits, lowest bit first.
   function automatic logic [3:0] thermo(input logic [2:0] n);
      logic [4:0] t;
      t = (5'd1 << n) - 5'd1;
      return t[3:0];
   endfunction

   // Digit i of a 4-digit code; digit 0 sits in the top nibble.
   function automatic logic [3:0] nibble(input logic [15:0] code, input logic [1:0] i);
      return code[4*(3-int'(i)) +: 4];
   endfunction

endpackage

// File: rtl/comb_lock_if.sv
// Keypad-in / LED-out bundle between the keypad decoder and the lock controller.
interface comb_lock_if;
   logic       newkey;
   logic [4:0] keycode;
   logic [5:0] led;

   modport master (output newkey, keycode, input led);
   modport slave  (input newkey, keycode, output led);
endinterface

// File: rtl/comb_lock_keyev.sv
// Turns the level newkey strobe into single-cycle, classified key events.
module comb_lock_keyev
   import comb_lock_pkg::*;
(
   input  logic       clk5,
   input  logic       reset,
   input  logic       newkey,
   input  logic [4:0] keycode,
   output logic       ev_digit,
   output logic       ev_prog,
   output logic       ev_cancel,
   output logic [3:0] ev_val
);
   logic newkey_q;

   always_ff @(posedge clk5) begin
      if (reset) newkey_q <= 1'b0;
      else       newkey_q <= newkey;
   end

   // A held strobe yields one event; keys A-D fall through every class.
   wire ev = newkey & ~newkey_q & keycode[4];

   assign ev_val    = keycode[3:0];
   assign ev_digit  = ev && (keycode[3:0] <= 4'd9);
   assign ev_prog   = ev && (keycode[3:0] == KEY_PROG);
   assign ev_cancel = ev && (keycode[3:0] == KEY_CANCEL);
endmodule

// File: rtl/comb_lock_ctrl.sv
// Combination-lock sequencer: entry, check, unlock window, lockout.
// Define COMB_LOCK_PROG_EN to let an unlocked user program a new code.
module comb_lock_ctrl #(
   parameter logic [15:0] DEFAULT_CODE   = 16'h1296,
   parameter int          MAX_FAIL       = 3,
   parameter int          OPEN_CYCLES    = 32,
   parameter int          LOCKOUT_CYCLES = 64,
   parameter int          TIMEOUT_CYCLES = 48
) (
   input logic       clk5,
   input logic       reset,
   comb_lock_if.slave bus
);
   import comb_lock_pkg::*;

   localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES)
                         ? ((OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES)
                         : ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
   localparam int TW = $clog2(TMAX + 1);
   localparam int FW = $clog2(MAX_FAIL + 1);

   // Loaded with N-1 so the state occupies exactly N cycles before expiry acts.
   localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAIL);

   logic          ev_digit, ev_prog, ev_cancel;
   logic [3:0]    ev_val;
   state_e        state;
   logic [2:0]    idx;
   logic          mismatch;
   logic [FW-1:0] fail_cnt;
   logic [TW-1:0] timer;
   logic [5:0]    led_d;

`ifdef COMB_LOCK_PROG_EN
   logic [15:0] code;
   logic [11:0] shadow;
`else
   wire [15:0] code = DEFAULT_CODE;
   wire        prog_unused = ev_prog;
`endif

   comb_lock_keyev u_keyev (
      .clk5      (clk5),
      .reset     (reset),
      .newkey    (bus.newkey),
      .keycode   (bus.keycode),
      .ev_digit  (ev_digit),
      .ev_prog   (ev_prog),
      .ev_cancel (ev_cancel),
      .ev_val    (ev_val)
   );

   always_ff @(posedge clk5) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         mismatch <= 1'b0;
         fail_cnt <= '0;
         timer    <= '0;
`ifdef COMB_LOCK_PROG_EN
         code     <= DEFAULT_CODE;
         shadow   <= '0;
`endif
      end else begin
         if (timer != '0) timer <= timer - 1'b1;
         unique case (state)
            IDLE: if (ev_digit) begin
               idx      <= 3'd1;
               mismatch <= (ev_val != nibble(code, 2'd0));
               timer    <= T_TO;
               state    <= ENTRY;
            end
            ENTRY: begin
               // A digit on the expiry cycle still counts.
               if (ev_digit) begin
                  mismatch <= mismatch | (ev_val != nibble(code, idx[1:0]));
                  idx      <= idx + 3'd1;
                  timer    <= T_TO;
                  if (idx == 3'(CODE_LEN - 1)) state <= CHECK;
               end else if (ev_cancel || timer == '0) begin
                  state <= IDLE;
               end
            end
            CHECK: begin
               if (!mismatch) begin
                  fail_cnt <= '0;
                  timer    <= T_OPEN;
                  state    <= OPEN;
               end else begin
                  fail_cnt <= fail_cnt + 1'b1;
                  if (fail_cnt + 1'b1 == F_MAX) begin
                     timer <= T_LOCK;
                     state <= LOCKOUT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            OPEN: begin
               if (ev_cancel) state <= IDLE;
`ifdef COMB_LOCK_PROG_EN
               else if (ev_prog) begin
                  idx   <= '0;
                  timer <= T_TO;
                  state <= PROG;
               end
`endif
               else if (timer == '0) state <= IDLE;
            end
            PROG: begin
`ifdef COMB_LOCK_PROG_EN
               if (ev_digit) begin
                  shadow <= {shadow[7:0], ev_val};
                  idx    <= idx + 3'd1;
                  timer  <= T_TO;
                  if (idx == 3'(CODE_LEN - 1)) begin
                     code  <= {shadow, ev_val};
                     state <= IDLE;
                  end
               end else if (ev_cancel || timer == '0) begin
                  state <= IDLE;
               end
`else
               state <= IDLE;
`endif
            end
            LOCKOUT: if (timer == '0) begin
               fail_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      led_d = '0;
      unique case (state)
         ENTRY, CHECK: led_d[3:0] = thermo(idx);
         OPEN:         led_d[LED_OPEN] = 1'b1;
         PROG: begin
            led_d[3:0]      = thermo(idx);
            led_d[LED_OPEN] = 1'b1;
            led_d[LED_LOCK] = 1'b1;
         end
         LOCKOUT:      led_d[LED_LOCK] = 1'b1;
         default:      led_d = '0;
      endcase
   end

   assign bus.led = led_d;
endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Bench for comb_lock_ctrl: directed scenarios plus random key traffic, checked each
// cycle against a deadline/queue based reference model.
module tb_comb_lock_ctrl;
   localparam logic [15:0] DEFAULT_CODE   = 16'h1296;
   localparam int          MAX_FAIL       = 3;
   localparam int          OPEN_CYCLES    = 32;
   localparam int          LOCKOUT_CYCLES = 64;
   localparam int          TIMEOUT_CYCLES = 48;
`ifdef COMB_LOCK_PROG_EN
   localparam bit PROG_EN = 1'b1;
`else
   localparam bit PROG_EN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_PROG = 4, M_LOCK = 5;

   logic clk5 = 1'b0;
   logic reset;
   always #5 clk5 = ~clk5;

   comb_lock_if bus();

   comb_lock_ctrl #(
      .DEFAULT_CODE(DEFAULT_CODE), .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_CYCLES),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk5  (clk5),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int open_seen, lock_seen;

   // Reference model: mode plus absolute deadlines and a queue of entered digits.
   int         m_mode = M_IDLE;
   logic [3:0] m_digits[$];
   logic [15:0] m_code = DEFAULT_CODE;
   int         m_fail = 0;
   int         m_deadline = 0;
   int         cyc = 0;
   bit         m_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [3:0] code_digit(input logic [15:0] c, input int i);
      return c[4*(3-i) +: 4];
   endfunction

   function automatic logic [15:0] packed_entry();
      logic [15:0] v = '0;
      foreach (m_digits[i]) v = {v[11:0], m_digits[i]};
      return v;
   endfunction

   function automatic logic [5:0] exp_led();
      logic [5:0] l = '0;
      logic [3:0] th;
      th = 4'((1 << m_digits.size()) - 1);
      case (m_mode)
         M_ENTRY: l[3:0] = th;
         M_OPEN:  l = 6'b010000;
         M_PROG:  l = {2'b11, th};
         M_LOCK:  l = 6'b100000;
         default: l = '0;
      endcase
      return l;
   endfunction

   // Applies the rules for the edge about to sample the current inputs.
   task automatic model_step();
      bit ev, dig, can, prg, expired;
      logic [3:0] k;
      cyc++;
      if (reset) begin
         m_mode = M_IDLE; m_digits.delete(); m_fail = 0; m_code = DEFAULT_CODE; m_prev = 1'b0;
         return;
      end
      ev = bus.newkey && !m_prev && bus.keycode[4];
      m_prev = bus.newkey;
      k = bus.keycode[3:0];
      dig = ev && (k <= 4'd9);
      can = ev && (k == 4'hF);
      prg = ev && (k == 4'hE) && PROG_EN;
      expired = (cyc >= m_deadline);
      case (m_mode)
         M_IDLE: if (dig) begin
            m_digits.delete(); m_digits.push_back(k);
            m_deadline = cyc + TIMEOUT_CYCLES; m_mode = M_ENTRY;
         end
         M_ENTRY: begin
            if (dig) begin
               m_digits.push_back(k); m_deadline = cyc + TIMEOUT_CYCLES;
               if (m_digits.size() == 4) m_mode = M_CHECK;
            end else if (can || expired) m_mode = M_IDLE;
         end
         M_CHECK: begin
            if (packed_entry() == m_code) begin
               m_fail = 0; m_deadline = cyc + OPEN_CYCLES; m_mode = M_OPEN;
            end else begin
               m_fail++;
               if (m_fail == MAX_FAIL) begin
                  m_deadline = cyc + LOCKOUT_CYCLES; m_mode = M_LOCK;
               end else m_mode = M_IDLE;
            end
         end
         M_OPEN: begin
            if (can) m_mode = M_IDLE;
            else if (prg) begin
               m_digits.delete(); m_deadline = cyc + TIMEOUT_CYCLES; m_mode = M_PROG;
            end else if (expired) m_mode = M_IDLE;
         end
         M_PROG: begin
            if (dig) begin
               m_digits.push_back(k); m_deadline = cyc + TIMEOUT_CYCLES;
               if (m_digits.size() == 4) begin
                  m_code = packed_entry(); m_mode = M_IDLE;
               end
            end else if (can || expired) m_mode = M_IDLE;
         end
         M_LOCK: if (expired) begin
            m_fail = 0; m_mode = M_IDLE;
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic tick();
      model_step();
      @(posedge clk5);
      @(negedge clk5);
      if (m_mode != M_CHECK) chk("led", 32'(bus.led), 32'(exp_led()));
      if (bus.led[4]) open_seen++;
      if (bus.led[5]) lock_seen++;
   endtask

   task automatic press(input logic [4:0] kc, input int hold, input int gap);
      bus.keycode = kc;
      bus.newkey  = 1'b1;
      repeat (hold) tick();
      bus.newkey  = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic enter(input logic [15:0] c);
      for (int i = 0; i < 4; i++) press({1'b1, code_digit(c, i)}, 1, 7);
   endtask

   task automatic do_reset();
      bus.newkey = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      bus.newkey = 1'b0;
      bus.keycode = '0;
      reset = 1'b1;
      repeat (3) tick();
      chk("reset_led", 32'(bus.led), 32'h0);
      reset = 1'b0;

      // Correct entry opens for exactly OPEN_CYCLES.
      open_seen = 0;
      press(5'b10001, 1, 7);
      chk("thermo1", 32'(bus.led), 32'b000001);
      press(5'b10010, 1, 7);
      chk("thermo2", 32'(bus.led), 32'b000011);
      press(5'b11001, 1, 7);
      chk("thermo3", 32'(bus.led), 32'b000111);
      press(5'b10110, 1, 7);
      repeat (40) tick();
      chk("open_len", 32'(open_seen), 32'(OPEN_CYCLES));

      // Three wrong entries lock out for exactly LOCKOUT_CYCLES.
      lock_seen = 0;
      repeat (2) begin enter(16'h1297); repeat (5) tick(); end
      chk("no_early_lock", 32'(lock_seen), 32'h0);
      enter(16'h1297);
      repeat (70) tick();
      chk("lock_len", 32'(lock_seen), 32'(LOCKOUT_CYCLES));
      open_seen = 0;
      enter(16'h1296);
      repeat (40) tick();
      chk("reopen", 32'(open_seen), 32'(OPEN_CYCLES));

      // Cancel and timeout count no failure.
      press(5'b10001, 1, 3);
      press(5'b10010, 1, 3);
      press(5'b11111, 1, 1);
      chk("cancel_idle", 32'(bus.led), 32'h0);
      press(5'b10001, 1, TIMEOUT_CYCLES);
      chk("timeout_idle", 32'(bus.led), 32'h0);
      lock_seen = 0;
      repeat (2) begin enter(16'h1297); repeat (5) tick(); end
      chk("fail_cnt_clear", 32'(lock_seen), 32'h0);
      open_seen = 0;
      enter(16'h1296);
      repeat (40) tick();
      chk("open_after_cancel", 32'(open_seen), 32'(OPEN_CYCLES));

      // Held strobe gives one digit.
      press(5'b10001, 5, 2);
      chk("held", 32'(bus.led), 32'b000001);
      press(5'b11111, 1, 3);

`ifdef COMB_LOCK_PROG_EN
      enter(16'h1296);
      press(5'b11110, 1, 3);
      chk("prog_led", 32'(bus.led[5:4]), 32'b11);
      enter(16'h4321);
      chk("prog_done", 32'(bus.led), 32'h0);
      open_seen = 0;
      enter(16'h1296); repeat (5) tick();
      chk("old_code_fails", 32'(open_seen), 32'h0);
      enter(16'h4321); repeat (40) tick();
      chk("new_code_opens", 32'(open_seen), 32'(OPEN_CYCLES));
      enter(16'h4321);
      press(5'b11110, 1, 3);
      press(5'b10100, 1, 3);
      press(5'b10011, 1, 3);
      do_reset();
      chk("reset_mid_prog", 32'(bus.led), 32'h0);
      open_seen = 0;
      enter(16'h1296); repeat (40) tick();
      chk("default_after_reset", 32'(open_seen), 32'(OPEN_CYCLES));
`endif

      // Random key traffic biased toward the current code.
      for (int t = 0; t < 1500; t++) begin
         int r, pos, gap;
         logic [4:0] kc;
         if ($urandom_range(0, 99) == 0) do_reset();
         r = $urandom_range(0, 99);
         pos = (m_mode == M_ENTRY || m_mode == M_PROG) ? m_digits.size() : 0;
         if (pos > 3) pos = 0;
         if (r < 65)      kc = {1'b1, code_digit(m_code, pos)};
         else if (r < 75) kc = {1'b1, 4'($urandom_range(0, 9))};
         else if (r < 82) kc = 5'b11110;
         else if (r < 90) kc = 5'b11111;
         else if (r < 95) kc = {1'b1, 4'($urandom_range(10, 13))};
         else             kc = {1'b0, 4'($urandom_range(0, 15))};
         gap = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 10);
         press(kc, $urandom_range(1, 3), gap);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
